// File: rtl/rs_agu_replay_sched_pkg.sv
// Shared types and sizing for the AGU replay scheduler.
package rs_agu_replay_sched_pkg;

  localparam int QUEUE_DEPTH = 4;
  localparam int HEADROOM    = 2;
  localparam int TAG_W       = 5;
  localparam int FIELD_W     = 5;

  // state    | meaning
  // ST_EMPTY | slot free
  // ST_WAIT  | missed load parked until the next cache refill
  // ST_READY | refill seen, eligible for replay issue
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } entry_state_e;

  typedef struct packed {
    logic [FIELD_W-1:0] pa;
    logic [FIELD_W-1:0] imm;
    logic [TAG_W-1:0]   tag;
  } op_t;

  typedef struct packed {
    entry_state_e state;
    op_t          op;
  } rq_entry_t;

  function automatic logic [TAG_W-1:0] rob_age(input logic [TAG_W-1:0] tag,
                                               input logic [TAG_W-1:0] ptr);
    return tag - ptr;
  endfunction

endpackage

// File: rtl/rs_agu_replay_sched_age_select4.sv
// Picks the oldest requesting entry relative to the ROB head; ties resolve to the lowest index.
module age_select4
  import rs_agu_replay_sched_pkg::*;
(
  input  logic [QUEUE_DEPTH-1:0]            req,
  input  logic [QUEUE_DEPTH-1:0][TAG_W-1:0] tag,
  input  logic [TAG_W-1:0]                  ptr_old,
  output logic [1:0]                        idx,
  output logic                              found
);

  logic [TAG_W-1:0] best_age;
  logic [TAG_W-1:0] cur_age;

  always_comb begin
    found    = 1'b0;
    idx      = '0;
    best_age = '1;
    cur_age  = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      cur_age = rob_age(tag[i], ptr_old);
      // strict compare keeps the earlier index on equal age
      if (req[i] && (!found || (cur_age < best_age))) begin
        found    = 1'b1;
        idx      = 2'(i);
        best_age = cur_age;
      end
    end
  end

endmodule

// File: rtl/rs_agu_replay_sched.sv
// AGU issue stage: merges RS ops with replays of cache-missed loads, with a one-entry skid.
module rs_agu_replay_sched
  import rs_agu_replay_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_rs,
  input  logic [FIELD_W-1:0] Pa_rs,
  input  logic [FIELD_W-1:0] Imm_rs,
  input  logic [TAG_W-1:0]   tag_ROB_rs,
  output logic               freeze_back_rs,
  output logic               valid_issue,
  output logic [FIELD_W-1:0] Pa_issue,
  output logic [FIELD_W-1:0] Imm_issue,
  output logic [TAG_W-1:0]   tag_ROB_issue,
  output logic               replay_issue,
  input  logic               ready_agu,
  input  logic               miss_valid,
  input  logic [FIELD_W-1:0] miss_Pa,
  input  logic [FIELD_W-1:0] miss_Imm,
  input  logic [TAG_W-1:0]   miss_tag_ROB,
  input  logic               refill_done,
  input  logic [TAG_W-1:0]   ptr_old,
  input  logic               flush,
  output logic               overflow_err
);

  rq_entry_t rq_q [QUEUE_DEPTH];
  rq_entry_t rq_d [QUEUE_DEPTH];
  op_t       skid_q, skid_d, out_q, out_d;
  logic      skid_valid_q, skid_valid_d;
  logic      out_valid_q, out_valid_d;
  logic      out_replay_q, out_replay_d;
  logic      overflow_err_q, overflow_err_d;

  logic [QUEUE_DEPTH-1:0]            ready_vec;
  logic [QUEUE_DEPTH-1:0][TAG_W-1:0] tag_vec;
  logic [2:0]                        busy_cnt;
  logic [1:0]                        sel_idx, miss_slot;
  logic                              sel_found, out_free, rs_taken, miss_hit;

  always_comb begin
    ready_vec = '0;
    tag_vec   = '0;
    busy_cnt  = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      ready_vec[i] = (rq_q[i].state == ST_READY);
      tag_vec[i]   = rq_q[i].op.tag;
      busy_cnt     = busy_cnt + {2'b00, (rq_q[i].state != ST_EMPTY)};
    end
  end

  age_select4 u_age_select4 (
    .req     (ready_vec),
    .tag     (tag_vec),
    .ptr_old (ptr_old),
    .idx     (sel_idx),
    .found   (sel_found)
  );

  assign out_free = !out_valid_q || ready_agu;

  // Stalling the RS while two entries are busy leaves room for misses already in flight.
  assign freeze_back_rs = skid_valid_q || (|ready_vec) || (busy_cnt >= 3'(HEADROOM))
                          || (out_valid_q && !ready_agu);

  always_comb begin
    rq_d           = rq_q;
    skid_d         = skid_q;
    skid_valid_d   = skid_valid_q;
    out_d          = out_q;
    out_valid_d    = out_valid_q;
    out_replay_d   = out_replay_q;
    overflow_err_d = overflow_err_q;
    rs_taken       = 1'b0;
    miss_hit       = 1'b0;
    miss_slot      = '0;

    if (refill_done) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (rq_q[i].state == ST_WAIT) rq_d[i].state = ST_READY;
      end
    end

    if (out_free) begin
      if (sel_found) begin
        out_d               = rq_q[sel_idx].op;
        out_valid_d         = 1'b1;
        out_replay_d        = 1'b1;
        rq_d[sel_idx].state = ST_EMPTY;
      end else if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        out_replay_d = 1'b0;
        skid_valid_d = 1'b0;
      end else if (valid_rs) begin
        out_d        = '{pa: Pa_rs, imm: Imm_rs, tag: tag_ROB_rs};
        out_valid_d  = 1'b1;
        out_replay_d = 1'b0;
        rs_taken     = 1'b1;
      end else begin
        out_d        = '0;
        out_valid_d  = 1'b0;
        out_replay_d = 1'b0;
      end
    end

    if (valid_rs && !rs_taken) begin
      skid_valid_d = 1'b1;
      skid_d       = '{pa: Pa_rs, imm: Imm_rs, tag: tag_ROB_rs};
    end

    // Slot search uses the current state so an entry freed by this cycle's replay stays unused.
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (!miss_hit && (rq_q[i].state == ST_EMPTY)) begin
        miss_hit  = 1'b1;
        miss_slot = 2'(i);
      end
    end
    if (miss_valid) begin
      if (miss_hit) begin
        rq_d[miss_slot].state = ST_WAIT;
        rq_d[miss_slot].op    = '{pa: miss_Pa, imm: miss_Imm, tag: miss_tag_ROB};
      end else begin
        overflow_err_d = 1'b1;
      end
    end

    if (flush) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) rq_d[i] = '0;
      skid_d         = '0;
      skid_valid_d   = 1'b0;
      out_d          = '0;
      out_valid_d    = 1'b0;
      out_replay_d   = 1'b0;
      overflow_err_d = overflow_err_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) rq_q[i] <= '0;
      skid_q         <= '0;
      skid_valid_q   <= 1'b0;
      out_q          <= '0;
      out_valid_q    <= 1'b0;
      out_replay_q   <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) rq_q[i] <= rq_d[i];
      skid_q         <= skid_d;
      skid_valid_q   <= skid_valid_d;
      out_q          <= out_d;
      out_valid_q    <= out_valid_d;
      out_replay_q   <= out_replay_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  assign valid_issue   = out_valid_q;
  assign Pa_issue      = out_q.pa;
  assign Imm_issue     = out_q.imm;
  assign tag_ROB_issue = out_q.tag;
  assign replay_issue  = out_replay_q;
  assign overflow_err  = overflow_err_q;

  a_skid_single: assert property (@(posedge clk) disable iff (!rst) valid_rs |-> !skid_valid_q)
    else $error("skid buffer received a second op while occupied");

endmodule

// File: tb/tb_rs_agu_replay_sched.sv
// Directed bench: expected AGU transfers queued by stimulus, popped by an independent monitor.
module tb_rs_agu_replay_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_rs;
  logic [4:0] Pa_rs, Imm_rs, tag_ROB_rs;
  logic       freeze_back_rs;
  logic       valid_issue;
  logic [4:0] Pa_issue, Imm_issue, tag_ROB_issue;
  logic       replay_issue;
  logic       ready_agu;
  logic       miss_valid;
  logic [4:0] miss_Pa, miss_Imm, miss_tag_ROB;
  logic       refill_done;
  logic [4:0] ptr_old;
  logic       flush;
  logic       overflow_err;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q [$];

  rs_agu_replay_sched dut (
    .clk            (clk),
    .rst            (rst),
    .valid_rs       (valid_rs),
    .Pa_rs          (Pa_rs),
    .Imm_rs         (Imm_rs),
    .tag_ROB_rs     (tag_ROB_rs),
    .freeze_back_rs (freeze_back_rs),
    .valid_issue    (valid_issue),
    .Pa_issue       (Pa_issue),
    .Imm_issue      (Imm_issue),
    .tag_ROB_issue  (tag_ROB_issue),
    .replay_issue   (replay_issue),
    .ready_agu      (ready_agu),
    .miss_valid     (miss_valid),
    .miss_Pa        (miss_Pa),
    .miss_Imm       (miss_Imm),
    .miss_tag_ROB   (miss_tag_ROB),
    .refill_done    (refill_done),
    .ptr_old        (ptr_old),
    .flush          (flush),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  // Transfer record: {Pa, Imm, tag, replay}
  always @(negedge clk) begin
    if (rst && valid_issue && ready_agu) begin
      logic [15:0] got, want;
      got = {Pa_issue, Imm_issue, tag_ROB_issue, replay_issue};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_issue got=%h required=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL issue_order got=%h required=%h", got, want);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    valid_rs    = 1'b0;
    miss_valid  = 1'b0;
    refill_done = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic rs_op(input logic [4:0] pa, input logic [4:0] imm, input logic [4:0] tag);
    valid_rs = 1'b1; Pa_rs = pa; Imm_rs = imm; tag_ROB_rs = tag;
  endtask

  task automatic miss(input logic [4:0] pa, input logic [4:0] imm, input logic [4:0] tag);
    miss_valid = 1'b1; miss_Pa = pa; miss_Imm = imm; miss_tag_ROB = tag;
  endtask

  function automatic logic [15:0] rec(input logic [4:0] pa, input logic [4:0] imm,
                                      input logic [4:0] tag, input logic rp);
    return {pa, imm, tag, rp};
  endfunction

  initial begin
    rst = 1'b0; ready_agu = 1'b1; ptr_old = '0;
    Pa_rs = '0; Imm_rs = '0; tag_ROB_rs = '0;
    miss_Pa = '0; miss_Imm = '0; miss_tag_ROB = '0;
    clr();
    tick(); tick();
    chk("reset_valid_issue", 16'(valid_issue), 16'd0);
    chk("reset_pa_issue", 16'(Pa_issue), 16'd0);
    chk("reset_overflow", 16'(overflow_err), 16'd0);
    chk("reset_freeze", 16'(freeze_back_rs), 16'd0);
    rst = 1'b1;

    // plain RS op, unobstructed
    tick();
    rs_op(5'd3, 5'd1, 5'd5); #1;
    chk("rs_freeze_pre", 16'(freeze_back_rs), 16'd0);
    exp_q.push_back(rec(5'd3, 5'd1, 5'd5, 1'b0));
    tick(); clr(); #1;
    chk("rs_valid", 16'(valid_issue), 16'd1);
    chk("rs_replay", 16'(replay_issue), 16'd0);
    chk("rs_freeze_post", 16'(freeze_back_rs), 16'd0);
    tick();
    chk("rs_drained", 16'(valid_issue), 16'd0);

    // two misses, oldest (tag 7) replays first
    ptr_old = 5'd6;
    miss(5'd10, 5'd2, 5'd9); tick();
    miss(5'd11, 5'd4, 5'd7); tick();
    clr(); refill_done = 1'b1; #1;
    chk("two_miss_freeze", 16'(freeze_back_rs), 16'd1);
    exp_q.push_back(rec(5'd11, 5'd4, 5'd7, 1'b1));
    exp_q.push_back(rec(5'd10, 5'd2, 5'd9, 1'b1));
    tick(); clr(); #1;
    chk("promote_no_issue_yet", 16'(valid_issue), 16'd0);
    chk("ready_freeze", 16'(freeze_back_rs), 16'd1);
    tick();
    chk("replay_first_tag", 16'(tag_ROB_issue), 16'd7);
    tick();
    chk("replay_second_tag", 16'(tag_ROB_issue), 16'd9);
    tick();
    chk("replay_drained", 16'(valid_issue), 16'd0);
    chk("replay_freeze_clear", 16'(freeze_back_rs), 16'd0);

    // backpressure with skid capture
    ptr_old = 5'd0;
    rs_op(5'd1, 5'd2, 5'd3); #1;
    chk("bp_freeze_pre", 16'(freeze_back_rs), 16'd0);
    exp_q.push_back(rec(5'd1, 5'd2, 5'd3, 1'b0));
    exp_q.push_back(rec(5'd4, 5'd5, 5'd6, 1'b0));
    tick();
    rs_op(5'd4, 5'd5, 5'd6); ready_agu = 1'b0; #1;
    chk("bp_freeze_stall", 16'(freeze_back_rs), 16'd1);
    tick(); clr(); #1;
    chk("bp_hold_pa", 16'(Pa_issue), 16'd1);
    chk("bp_freeze_skid", 16'(freeze_back_rs), 16'd1);
    tick();
    chk("bp_hold_tag", 16'(tag_ROB_issue), 16'd3);
    tick();
    ready_agu = 1'b1; #1;
    chk("bp_freeze_release", 16'(freeze_back_rs), 16'd1);
    tick();
    chk("bp_skid_out", {Pa_issue, Imm_issue, tag_ROB_issue, replay_issue},
        rec(5'd4, 5'd5, 5'd6, 1'b0));
    tick();
    chk("bp_drained", 16'(valid_issue), 16'd0);

    // five misses into four slots; wrap-around age order after refill
    ptr_old = 5'd22;
    for (int t = 20; t < 25; t++) begin
      miss(5'(t), 5'(t - 20), 5'(t));
      if (t == 24) begin
        #1;
        chk("ovf_before_fifth", 16'(overflow_err), 16'd0);
      end
      tick();
    end
    clr(); #1;
    chk("ovf_set", 16'(overflow_err), 16'd1);
    chk("ovf_freeze", 16'(freeze_back_rs), 16'd1);
    chk("ovf_wait_no_issue", 16'(valid_issue), 16'd0);
    exp_q.push_back(rec(5'd22, 5'd2, 5'd22, 1'b1));
    exp_q.push_back(rec(5'd23, 5'd3, 5'd23, 1'b1));
    exp_q.push_back(rec(5'd20, 5'd0, 5'd20, 1'b1));
    exp_q.push_back(rec(5'd21, 5'd1, 5'd21, 1'b1));
    refill_done = 1'b1; tick(); clr();
    tick();
    chk("wrap_first_tag", 16'(tag_ROB_issue), 16'd22);
    repeat (4) tick();
    chk("wrap_drained", 16'(valid_issue), 16'd0);
    chk("ovf_sticky", 16'(overflow_err), 16'd1);

    // same-cycle miss and refill: only the older WAIT entry is promoted
    ptr_old = 5'd0;
    miss(5'd7, 5'd0, 5'd2); tick();
    miss(5'd8, 5'd0, 5'd1); refill_done = 1'b1; tick(); clr(); #1;
    exp_q.push_back(rec(5'd7, 5'd0, 5'd2, 1'b1));
    exp_q.push_back(rec(5'd8, 5'd0, 5'd1, 1'b1));
    chk("same_cycle_no_issue", 16'(valid_issue), 16'd0);
    tick();
    chk("same_cycle_old_ready", 16'(tag_ROB_issue), 16'd2);
    tick();
    chk("same_cycle_new_wait_a", 16'(valid_issue), 16'd0);
    tick();
    chk("same_cycle_new_wait_b", 16'(valid_issue), 16'd0);
    refill_done = 1'b1; tick(); clr();
    tick();
    chk("same_cycle_late_tag", 16'(tag_ROB_issue), 16'd1);
    tick();
    chk("same_cycle_drained", 16'(valid_issue), 16'd0);

    // flush with queue, skid and output register all occupied
    miss(5'd10, 5'd0, 5'd10); tick(); clr();
    rs_op(5'd12, 5'd0, 5'd12); #1;
    chk("flush_setup_freeze", 16'(freeze_back_rs), 16'd0);
    tick();
    rs_op(5'd13, 5'd0, 5'd13); ready_agu = 1'b0; miss(5'd11, 5'd0, 5'd11);
    tick(); clr();
    flush = 1'b1; miss(5'd14, 5'd0, 5'd14); #1;
    chk("flush_pre_freeze", 16'(freeze_back_rs), 16'd1);
    chk("flush_pre_valid", 16'(valid_issue), 16'd1);
    tick(); clr(); #1;
    chk("flush_valid", 16'(valid_issue), 16'd0);
    chk("flush_fields", {Pa_issue, Imm_issue, tag_ROB_issue, replay_issue}, 16'd0);
    chk("flush_freeze", 16'(freeze_back_rs), 16'd0);
    chk("flush_ovf_held", 16'(overflow_err), 16'd1);
    ready_agu = 1'b1; refill_done = 1'b1; tick(); clr();
    repeat (2) tick();
    chk("flush_queue_empty", 16'(valid_issue), 16'd0);
    rs_op(5'd9, 5'd9, 5'd9); #1;
    chk("post_flush_freeze", 16'(freeze_back_rs), 16'd0);
    exp_q.push_back(rec(5'd9, 5'd9, 5'd9, 1'b0));
    tick(); clr();
    chk("post_flush_issue_tag", 16'(tag_ROB_issue), 16'd9);
    tick();

    // reset mid-operation discards a READY replay
    miss(5'd3, 5'd3, 5'd3); tick(); clr();
    refill_done = 1'b1; tick(); clr();
    rst = 1'b0; #1;
    chk("midrst_valid", 16'(valid_issue), 16'd0);
    chk("midrst_ovf", 16'(overflow_err), 16'd0);
    chk("midrst_freeze", 16'(freeze_back_rs), 16'd0);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("midrst_no_replay", 16'(valid_issue), 16'd0);

    chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
